// File: rtl/decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : decode_arbiter
//  Purpose  : N-channel round-robin arbiter feeding a FifoDepth-entry
//             first-word-fall-through queue for decode stage three.
//             Define DECODE_ARB_FIXED_PRIO_EN for fixed lowest-index priority
//             (no round-robin pointer is built in that case).
//  Revision : 1.0 - initial release
// ============================================================================
module decode_arbiter #(
    parameter int NumChannels    = 4,
    parameter int PayloadWidth   = 256,
    parameter int FifoDepth      = 4,
    parameter int ChannelIdWidth = $clog2(NumChannels),
    parameter int CountWidth     = $clog2(FifoDepth) + 1
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [NumChannels-1:0]              valid_i,
    output logic [NumChannels-1:0]              ready_o,
    input  logic [NumChannels*PayloadWidth-1:0] payload_i,
    input  logic                                flush_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [PayloadWidth-1:0]             payload_o,
    output logic [ChannelIdWidth-1:0]           channel_o,
    output logic [CountWidth-1:0]               count_o
);

    localparam int                    c_PTR_W = $clog2(FifoDepth);
    localparam logic [CountWidth-1:0] c_FULL  = CountWidth'(FifoDepth);

    logic [PayloadWidth-1:0]   r_mem_pay  [FifoDepth];
    logic [ChannelIdWidth-1:0] r_mem_chan [FifoDepth];
    logic [c_PTR_W-1:0]        r_wr;
    logic [c_PTR_W-1:0]        r_rd;
    logic [CountWidth-1:0]     r_count;

    logic                      w_found;
    logic [ChannelIdWidth-1:0] w_winner;
    logic                      w_space;
    logic                      w_push;
    logic                      w_pop;

`ifndef DECODE_ARB_FIXED_PRIO_EN
    logic [ChannelIdWidth-1:0] r_rr;
    logic [ChannelIdWidth-1:0] w_next_rr;
    logic [ChannelIdWidth:0]   w_rr_inc;
`endif

    // Find the first requesting channel, scanning upward from the search start.
    always_comb begin : search
        logic [ChannelIdWidth:0]   v_sum;
        logic [ChannelIdWidth-1:0] v_idx;
        v_sum    = '0;
        v_idx    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NumChannels; k++) begin
`ifdef DECODE_ARB_FIXED_PRIO_EN
            v_sum = (ChannelIdWidth+1)'(k);
`else
            // Sum is one bit wider so the wrap works for non-power-of-two counts.
            v_sum = {1'b0, r_rr} + (ChannelIdWidth+1)'(k);
            if (v_sum >= (ChannelIdWidth+1)'(NumChannels)) begin
                v_sum = v_sum - (ChannelIdWidth+1)'(NumChannels);
            end
`endif
            v_idx = v_sum[ChannelIdWidth-1:0];
            if (!w_found && valid_i[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

`ifndef DECODE_ARB_FIXED_PRIO_EN
    // Pointer after the winner, wrapping at NumChannels.
    always_comb begin
        w_rr_inc  = {1'b0, w_winner} + (ChannelIdWidth+1)'(1);
        w_next_rr = w_rr_inc[ChannelIdWidth-1:0];
        if (w_rr_inc == (ChannelIdWidth+1)'(NumChannels)) begin
            w_next_rr = '0;
        end
    end
`endif

    // No pass-through on full: ready never depends on the downstream ready.
    assign w_space = (r_count != c_FULL);
    assign ready_o = (w_found && w_space && !flush_i && reset_i)
                   ? (NumChannels'(1) << w_winner) : '0;
    assign w_push  = |(valid_i & ready_o);
    assign w_pop   = (r_count != '0) && ready_i && !flush_i;

    assign valid_o   = (r_count != '0);
    assign payload_o = r_mem_pay[r_rd];
    assign channel_o = r_mem_chan[r_rd];
    assign count_o   = r_count;

    // Queue storage, pointers, occupancy and arbitration pointer.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
`ifndef DECODE_ARB_FIXED_PRIO_EN
            r_rr    <= '0;
`endif
            for (int i = 0; i < FifoDepth; i++) begin
                r_mem_pay[i]  <= '0;
                r_mem_chan[i] <= '0;
            end
        end else if (flush_i) begin
            // Flush drops the queue but keeps the fairness pointer.
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (w_push) begin
                r_mem_pay[r_wr]  <= payload_i[w_winner*PayloadWidth +: PayloadWidth];
                r_mem_chan[r_wr] <= w_winner;
                r_wr             <= r_wr + c_PTR_W'(1);
`ifndef DECODE_ARB_FIXED_PRIO_EN
                r_rr             <= w_next_rr;
`endif
            end
            if (w_pop) begin
                r_rd <= r_rd + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CountWidth'(1);
                2'b01:   r_count <= r_count - CountWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_arbiter
//  Purpose  : Scoreboard bench for decode_arbiter (directed + random traffic).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_arbiter;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int D  = 4;

    typedef struct {
        logic [PW-1:0] p;
        logic [1:0]    c;
    } item_t;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    valid_i;
    logic [N-1:0]    ready_o;
    logic [N*PW-1:0] payload_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [PW-1:0]   payload_o;
    logic [1:0]      channel_o;
    logic [2:0]      count_o;

    int              checks = 0;
    int              errors = 0;
    item_t           sb[$];
    int              m_count = 0;
    int              m_rr = 0;
    logic [PW-1:0]   pay [N];

    always #5 clk = ~clk;

    decode_arbiter #(
        .NumChannels (N),
        .PayloadWidth(PW),
        .FifoDepth   (D)
    ) dut (
        .clock_i  (clk),
        .reset_i  (reset_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .payload_i(payload_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .payload_o(payload_o),
        .channel_o(channel_o),
        .count_o  (count_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every downstream handshake must match the oldest expected item.
    always @(negedge clk) begin
        if (reset_i && valid_o && ready_i && !flush_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_empty: got valid_o=1, expected empty queue (t=%0t)", $time);
            end else begin
                item_t e;
                e = sb.pop_front();
                chk("payload_o", 64'(payload_o), 64'(e.p));
                chk("channel_o", 64'(channel_o), 64'(e.c));
            end
        end
    end

    // One clock of stimulus; the reference model decides grants from the rules.
    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic fl);
        int  win;
        bit  exp_pop;
        valid_i = v;
        ready_i = rdy;
        flush_i = fl;
        for (int c = 0; c < N; c++) payload_i[c*PW +: PW] = pay[c];
        @(negedge clk);
        win = -1;
        if (!fl && m_count < D) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (win < 0 && v[c]) win = c;
            end
        end
        chk("ready_o", 64'(ready_o), (win >= 0) ? (64'd1 << win) : 64'd0);
        chk("count_o", 64'(count_o), 64'(m_count));
        chk("valid_o", 64'(valid_o), 64'(m_count != 0));
        exp_pop = !fl && (m_count > 0) && rdy;
        if (win >= 0) begin
            item_t e;
            e.p = pay[win];
            e.c = 2'(win);
            sb.push_back(e);
        end
        @(posedge clk);
        if (fl) begin
            sb.delete();
            m_count = 0;
        end else begin
            m_count = m_count + ((win >= 0) ? 1 : 0) - (exp_pop ? 1 : 0);
            if (win >= 0) begin
`ifndef DECODE_ARB_FIXED_PRIO_EN
                m_rr = (win + 1) % N;
`endif
                pay[win] = $urandom;
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid_o",   64'(valid_o),   64'd0);
        chk("rst_ready_o",   64'(ready_o),   64'd0);
        chk("rst_payload_o", 64'(payload_o), 64'd0);
        chk("rst_channel_o", 64'(channel_o), 64'd0);
        chk("rst_count_o",   64'(count_o),   64'd0);
    endtask

    task automatic release_reset();
        valid_i = '0;
        @(negedge clk);
        reset_i = 1'b1;
        sb.delete();
        m_count = 0;
        m_rr    = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int c = 0; c < N; c++) pay[c] = $urandom;
        reset_i   = 1'b0;
        valid_i   = '1;
        ready_i   = 1'b0;
        flush_i   = 1'b0;
        payload_i = '0;
        #3;
        check_reset_outputs();
        release_reset();

        // Lowest valid channel wins first after reset.
        cycle(4'b0101, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);

        // Round-robin with every channel requesting.
        repeat (8) cycle(4'b1111, 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // Backpressure: fill to full, fifth request refused, then drain.
        pay[2] = 32'hA1;
        repeat (5) cycle(4'b0100, 1'b0, 1'b0);
        repeat (6) cycle(4'b0100, 1'b1, 1'b0);
        repeat (5) cycle(4'b0000, 1'b1, 1'b0);

        // Simultaneous push and pop at count 2 across pointer wrap.
        repeat (2) cycle(4'b0010, 1'b0, 1'b0);
        repeat (12) cycle(4'b0010, 1'b1, 1'b0);
        repeat (4) cycle(4'b0000, 1'b1, 1'b0);

        // Flush at count 3 with channel 1 requesting.
        repeat (3) cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // Sparse requests: channel 3 then pointer wraps to channel 0.
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1001, 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // Reset mid-stream with three entries queued.
        repeat (3) cycle(4'b0100, 1'b0, 1'b0);
        valid_i = '1;
        reset_i = 1'b0;
        #2;
        check_reset_outputs();
        release_reset();
        cycle(4'b0101, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end
        repeat (6) cycle(4'b0000, 1'b1, 1'b0);
        chk("final_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
